// File: rtl/combat_pkg.sv
// -----------------------------------------------------------------------------
// combat_pkg
// Shared definitions for the combat resolver slice:
//   - attack type encodings coming from player_core
//   - active-frame windows for light and heavy attacks
//   - hitstun counter sizing (doubled when COUNTER_HIT_EN is defined)
// Configuration macro: COUNTER_HIT_EN
// -----------------------------------------------------------------------------
package combat_pkg;

    // Encodings 0 and 3 both mean "no attack"; only 1 and 2 can ever land.
    typedef enum logic [1:0] {
        ATK_NONE  = 2'd0,
        ATK_LIGHT = 2'd1,
        ATK_HEAVY = 2'd2
    } atk_type_e;

    // Inclusive active windows, in attack frames.
    localparam logic [5:0] LIGHT_WIN_LO = 6'd4;
    localparam logic [5:0] LIGHT_WIN_HI = 6'd8;
    localparam logic [5:0] HEAVY_WIN_LO = 6'd8;
    localparam logic [5:0] HEAVY_WIN_HI = 6'd14;

`ifdef COUNTER_HIT_EN
    localparam int STUN_MULT = 2;
`else
    localparam int STUN_MULT = 1;
`endif

    // Width of a hitstun counter able to hold the longest possible stun.
    function automatic int stun_width(input int frames);
        return $clog2(frames * STUN_MULT + 1);
    endfunction

endpackage

// File: rtl/combat_resolver_if.sv
// -----------------------------------------------------------------------------
// combat_resolver_if
// Bundle between the two player cores / scene logic and the combat resolver.
//   master : game side; drives SCEN, positions, facing and attack state,
//            receives hitstun, health, hit pulses and KO.
//   slave  : combat_resolver.
// Signals:
//   SCEN                   game-tick enable, one-cycle pulse per frame
//   pN_pos_x / pN_pos_y    player positions
//   pN_face_right          facing
//   pN_attack_active/type/frame  attack state
//   pN_hitstun_active      hitstun flag back to each player_core
//   pN_hp                  health
//   hit_pulse              bit0 P1 struck P2, bit1 P2 struck P1 (one cycle)
//   ko                     bit0 P1 down, bit1 P2 down (sticky)
// -----------------------------------------------------------------------------
interface combat_resolver_if
    import combat_pkg::*;
#(
    parameter int POS_WIDTH = 10,
    parameter int HP_WIDTH  = 7
) ();

    logic                 SCEN;
    logic [POS_WIDTH-1:0] p1_pos_x;
    logic [POS_WIDTH-1:0] p2_pos_x;
    logic [POS_WIDTH-1:0] p1_pos_y;
    logic [POS_WIDTH-1:0] p2_pos_y;
    logic                 p1_face_right;
    logic                 p2_face_right;
    logic                 p1_attack_active;
    logic                 p2_attack_active;
    atk_type_e            p1_attack_type;
    atk_type_e            p2_attack_type;
    logic [5:0]           p1_attack_frame;
    logic [5:0]           p2_attack_frame;
    logic                 p1_hitstun_active;
    logic                 p2_hitstun_active;
    logic [HP_WIDTH-1:0]  p1_hp;
    logic [HP_WIDTH-1:0]  p2_hp;
    logic [1:0]           hit_pulse;
    logic [1:0]           ko;

    modport master (
        output SCEN,
        output p1_pos_x, p2_pos_x, p1_pos_y, p2_pos_y,
        output p1_face_right, p2_face_right,
        output p1_attack_active, p2_attack_active,
        output p1_attack_type, p2_attack_type,
        output p1_attack_frame, p2_attack_frame,
        input  p1_hitstun_active, p2_hitstun_active,
        input  p1_hp, p2_hp, hit_pulse, ko
    );

    modport slave (
        input  SCEN,
        input  p1_pos_x, p2_pos_x, p1_pos_y, p2_pos_y,
        input  p1_face_right, p2_face_right,
        input  p1_attack_active, p2_attack_active,
        input  p1_attack_type, p2_attack_type,
        input  p1_attack_frame, p2_attack_frame,
        output p1_hitstun_active, p2_hitstun_active,
        output p1_hp, p2_hp, hit_pulse, ko
    );

endinterface

// File: rtl/fighter_damage_track.sv
// -----------------------------------------------------------------------------
// fighter_damage_track
// Per-player combat state: health, hitstun counter, KO flag, and the
// "landed" latch that limits this player's own attack to one hit.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   scen            game tick
//   attack_active   this player's attack in progress (clears landed latch)
//   landed_set      this player's attack hit the opponent this tick
//   struck          this player was hit this tick (already tick-qualified)
//   dmg, stun_len   damage and hitstun applied when struck
//   hp              health (registered)
//   hitstun_active  hitstun counter nonzero (registered)
//   landed          landed latch
//   down            sticky KO flag
// -----------------------------------------------------------------------------
module fighter_damage_track
    import combat_pkg::*;
#(
    parameter int HP_WIDTH = 7,
    parameter int HP_MAX   = 100,
    parameter int STUN_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scen,
    input  logic                attack_active,
    input  logic                landed_set,
    input  logic                struck,
    input  logic [HP_WIDTH-1:0] dmg,
    input  logic [STUN_W-1:0]   stun_len,
    output logic [HP_WIDTH-1:0] hp,
    output logic                hitstun_active,
    output logic                landed,
    output logic                down
);

    logic [STUN_W-1:0]   stun_cnt;
    logic [STUN_W-1:0]   stun_next;
    logic [HP_WIDTH-1:0] hp_next;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave it unassigned and infer a latch.
        hp_next   = hp;
        stun_next = stun_cnt;
        if (struck) begin
            hp_next   = (hp > dmg) ? hp - dmg : '0;
            stun_next = stun_len;
        end else if (scen && stun_cnt != '0) begin
            stun_next = stun_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hp             <= HP_WIDTH'(HP_MAX);
            stun_cnt       <= '0;
            hitstun_active <= 1'b0;
            landed         <= 1'b0;
            down           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            hp             <= hp_next;
            stun_cnt       <= stun_next;
            hitstun_active <= (stun_next != '0);
            down           <= down | (struck && hp_next == '0);
            if (landed_set) begin
                landed <= 1'b1;
            end else if (scen && !attack_active) begin
                landed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/combat_resolver.sv
// -----------------------------------------------------------------------------
// combat_resolver
// Decides hits between two player_cores each game tick (SCEN), applies
// damage/hitstun through one fighter_damage_track per player, and reports
// health, one-cycle hit pulses and sticky KO flags. All outputs registered.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset (dominates SCEN)
//   bus    combat_resolver_if.slave (player state in, combat results out)
// Configuration macro: COUNTER_HIT_EN -- a defender struck while its own
// attack is active takes 1.5x damage and double hitstun.
// -----------------------------------------------------------------------------
module combat_resolver
    import combat_pkg::*;
#(
    parameter int POS_WIDTH      = 10,
    parameter int HP_WIDTH       = 7,
    parameter int HP_MAX         = 100,
    parameter int HITSTUN_FRAMES = 20,
    parameter int REACH_LIGHT    = 40,
    parameter int REACH_HEAVY    = 56,
    parameter int Y_TOL          = 48,
    parameter int DMG_LIGHT      = 5,
    parameter int DMG_HEAVY      = 12
) (
    input  logic                clk,
    input  logic                reset,
    combat_resolver_if.slave    bus
);

    localparam int STUN_W = stun_width(HITSTUN_FRAMES);
    localparam int DW     = POS_WIDTH + 1;

    localparam logic [DW-1:0] REACH_L = DW'(REACH_LIGHT);
    localparam logic [DW-1:0] REACH_H = DW'(REACH_HEAVY);
    localparam logic [DW-1:0] Y_LIM   = DW'(Y_TOL);

    // One extra bit so the magnitude never wraps.
    function automatic logic [DW-1:0] abs_diff(input logic [POS_WIDTH-1:0] a,
                                               input logic [POS_WIDTH-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    function automatic logic in_window(input atk_type_e t, input logic [5:0] f);
        case (t)
            ATK_LIGHT: return (f >= LIGHT_WIN_LO) && (f <= LIGHT_WIN_HI);
            ATK_HEAVY: return (f >= HEAVY_WIN_LO) && (f <= HEAVY_WIN_HI);
            default:   return 1'b0;
        endcase
    endfunction

    // Attacker-side geometry and timing; dx = 0 satisfies either facing.
    function automatic logic strike_ok(
        input logic                 active,
        input atk_type_e            t,
        input logic [5:0]           frame,
        input logic                 face_right,
        input logic [POS_WIDTH-1:0] ax,
        input logic [POS_WIDTH-1:0] ay,
        input logic [POS_WIDTH-1:0] dx,
        input logic [POS_WIDTH-1:0] dy
    );
        logic facing_ok;
        logic reach_ok;
        facing_ok = face_right ? (dx >= ax) : (dx <= ax);
        reach_ok  = abs_diff(ax, dx) <= ((t == ATK_HEAVY) ? REACH_H : REACH_L);
        return active && in_window(t, frame) && facing_ok && reach_ok
               && (abs_diff(ay, dy) <= Y_LIM);
    endfunction

    logic                p1_strikes;
    logic                p2_strikes;
    logic [HP_WIDTH-1:0] p1_dmg;
    logic [HP_WIDTH-1:0] p2_dmg;
    logic [STUN_W-1:0]   p1_stun;
    logic [STUN_W-1:0]   p2_stun;
    logic                p1_landed;
    logic                p2_landed;
    logic                p1_down;
    logic                p2_down;
    logic                p1_stunned;
    logic                p2_stunned;
    logic [1:0]          hit_pulse_q;

    // pN_dmg / pN_stun describe what player N inflicts on the opponent.
    always_comb begin
        p1_dmg  = (bus.p1_attack_type == ATK_HEAVY) ? HP_WIDTH'(DMG_HEAVY)
                                                    : HP_WIDTH'(DMG_LIGHT);
        p2_dmg  = (bus.p2_attack_type == ATK_HEAVY) ? HP_WIDTH'(DMG_HEAVY)
                                                    : HP_WIDTH'(DMG_LIGHT);
        p1_stun = STUN_W'(HITSTUN_FRAMES);
        p2_stun = STUN_W'(HITSTUN_FRAMES);
`ifdef COUNTER_HIT_EN
        if (bus.p2_attack_active) begin
            p1_dmg  = p1_dmg + (p1_dmg >> 1);
            p1_stun = STUN_W'(2 * HITSTUN_FRAMES);
        end
        if (bus.p1_attack_active) begin
            p2_dmg  = p2_dmg + (p2_dmg >> 1);
            p2_stun = STUN_W'(2 * HITSTUN_FRAMES);
        end
`endif
    end

    // Both directions are evaluated from the same pre-tick state, so a trade
    // lands both hits on the same tick.
    always_comb begin
        p1_strikes = bus.SCEN && !p1_landed && !p2_stunned && !p1_down && !p2_down
                     && strike_ok(bus.p1_attack_active, bus.p1_attack_type,
                                  bus.p1_attack_frame, bus.p1_face_right,
                                  bus.p1_pos_x, bus.p1_pos_y,
                                  bus.p2_pos_x, bus.p2_pos_y);
        p2_strikes = bus.SCEN && !p2_landed && !p1_stunned && !p1_down && !p2_down
                     && strike_ok(bus.p2_attack_active, bus.p2_attack_type,
                                  bus.p2_attack_frame, bus.p2_face_right,
                                  bus.p2_pos_x, bus.p2_pos_y,
                                  bus.p1_pos_x, bus.p1_pos_y);
    end

    fighter_damage_track #(
        .HP_WIDTH (HP_WIDTH),
        .HP_MAX   (HP_MAX),
        .STUN_W   (STUN_W)
    ) u_p1_track (
        .clk            (clk),
        .reset          (reset),
        .scen           (bus.SCEN),
        .attack_active  (bus.p1_attack_active),
        .landed_set     (p1_strikes),
        .struck         (p2_strikes),
        .dmg            (p2_dmg),
        .stun_len       (p2_stun),
        .hp             (bus.p1_hp),
        .hitstun_active (p1_stunned),
        .landed         (p1_landed),
        .down           (p1_down)
    );

    fighter_damage_track #(
        .HP_WIDTH (HP_WIDTH),
        .HP_MAX   (HP_MAX),
        .STUN_W   (STUN_W)
    ) u_p2_track (
        .clk            (clk),
        .reset          (reset),
        .scen           (bus.SCEN),
        .attack_active  (bus.p2_attack_active),
        .landed_set     (p2_strikes),
        .struck         (p1_strikes),
        .dmg            (p1_dmg),
        .stun_len       (p1_stun),
        .hp             (bus.p2_hp),
        .hitstun_active (p2_stunned),
        .landed         (p2_landed),
        .down           (p2_down)
    );

    // Strike terms are already tick-qualified, so non-SCEN cycles clear this.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_pulse_q <= 2'b00;
        end else begin
            hit_pulse_q <= {p2_strikes, p1_strikes};
        end
    end

    assign bus.hit_pulse         = hit_pulse_q;
    assign bus.ko                = {p2_down, p1_down};
    assign bus.p1_hitstun_active = p1_stunned;
    assign bus.p2_hitstun_active = p2_stunned;

endmodule

// File: tb/tb_combat_resolver.sv
// -----------------------------------------------------------------------------
// tb_combat_resolver
// Directed-vector bench for combat_resolver. Expected values are hand-derived
// from the combat rules; COUNTER_HIT_EN selects the alternate expectations.
// -----------------------------------------------------------------------------
module tb_combat_resolver;
    import combat_pkg::*;

    logic clk;
    logic reset;

    combat_resolver_if #(.POS_WIDTH(10), .HP_WIDTH(7)) bus ();

    combat_resolver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-scenario observations gathered by tick().
    int hits1, hits2, stun1, stun2, stray, hit_frame;
    logic [1:0] first_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_obs();
        hits1 = 0; hits2 = 0; stun1 = 0; stun2 = 0; stray = 0;
        hit_frame = -1; first_pulse = 2'b00;
    endtask

    // One game tick: SCEN high for one edge, sample results after that edge,
    // then one idle edge to confirm the pulse does not linger.
    task automatic tick(input int frame);
        logic [1:0] p;
        @(negedge clk);
        bus.SCEN = 1'b1;
        @(negedge clk);
        bus.SCEN = 1'b0;
        p = bus.hit_pulse;
        if (p[0]) hits1++;
        if (p[1]) hits2++;
        if (p != 2'b00 && first_pulse == 2'b00) begin
            first_pulse = p;
            hit_frame   = frame;
        end
        if (bus.p1_hitstun_active) stun1++;
        if (bus.p2_hitstun_active) stun2++;
        @(negedge clk);
        if (bus.hit_pulse != 2'b00) stray++;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(-1);
    endtask

    task automatic run_frames(input int lo, input int hi);
        for (int f = lo; f <= hi; f++) begin
            bus.p1_attack_frame = 6'(f);
            bus.p2_attack_frame = 6'(f);
            tick(f);
        end
    endtask

    task automatic setup(input int x1, input int x2, input int y1, input int y2,
                         input logic f1, input logic f2);
        bus.p1_pos_x = 10'(x1); bus.p2_pos_x = 10'(x2);
        bus.p1_pos_y = 10'(y1); bus.p2_pos_y = 10'(y2);
        bus.p1_face_right = f1; bus.p2_face_right = f2;
        bus.p1_attack_active = 1'b0; bus.p2_attack_active = 1'b0;
        bus.p1_attack_type = ATK_NONE; bus.p2_attack_type = ATK_NONE;
        bus.p1_attack_frame = 6'd0; bus.p2_attack_frame = 6'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_obs();
    endtask

    // P1 performs one full attack on P2, then the stun drains.
    task automatic p1_attack(input atk_type_e t);
        bus.p1_attack_type   = t;
        bus.p1_attack_active = 1'b1;
        run_frames(0, 15);
        bus.p1_attack_active = 1'b0;
        idle_ticks(22);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.SCEN = 1'b0;
        setup(100, 130, 200, 200, 1'b1, 1'b0);
        do_reset();

        // Reset state
        check("rst_p1_hp", 32'(bus.p1_hp), 100);
        check("rst_p2_hp", 32'(bus.p2_hp), 100);
        check("rst_ko", 32'(bus.ko), 0);
        check("rst_pulse", 32'(bus.hit_pulse), 0);
        check("rst_stun", 32'({bus.p1_hitstun_active, bus.p2_hitstun_active}), 0);

        // Light attack, facing right, dx=30: single hit at frame 4
        bus.p1_attack_type = ATK_LIGHT;
        bus.p1_attack_active = 1'b1;
        run_frames(0, 10);
        bus.p1_attack_active = 1'b0;
        idle_ticks(30);
        check("light_hits", 32'(hits1), 1);
        check("light_frame", 32'(hit_frame), 4);
        check("light_pulse", 32'(first_pulse), 32'b01);
        check("light_stray", 32'(stray), 0);
        check("light_p2_hp", 32'(bus.p2_hp), 95);
        check("light_p1_hp", 32'(bus.p1_hp), 100);
        check("light_stun_ticks", 32'(stun2), 20);
        check("light_p1_stun", 32'(stun1), 0);

        // Facing away: no hit
        setup(100, 130, 200, 200, 1'b0, 1'b0);
        do_reset();
        p1_attack(ATK_LIGHT);
        check("face_away_hits", 32'(hits1), 0);
        check("face_away_hp", 32'(bus.p2_hp), 100);

        // dx=0 hits even when facing left
        setup(100, 100, 200, 200, 1'b0, 1'b0);
        do_reset();
        p1_attack(ATK_LIGHT);
        check("dx0_hits", 32'(hits1), 1);

        // Heavy at max reach, then reset mid-hitstun with SCEN high
        setup(100, 156, 200, 200, 1'b1, 1'b0);
        do_reset();
        bus.p1_attack_type = ATK_HEAVY;
        bus.p1_attack_active = 1'b1;
        run_frames(0, 15);
        check("heavy56_hits", 32'(hits1), 1);
        check("heavy56_frame", 32'(hit_frame), 8);
        check("heavy56_hp", 32'(bus.p2_hp), 88);
        check("heavy56_stun_on", 32'(bus.p2_hitstun_active), 1);
        @(negedge clk);
        bus.SCEN = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        bus.SCEN = 1'b0;
        reset = 1'b0;
        check("rst_mid_stun", 32'(bus.p2_hitstun_active), 0);
        check("rst_mid_hp", 32'(bus.p2_hp), 100);
        check("rst_mid_pulse", 32'(bus.hit_pulse), 0);

        // Heavy one past reach
        setup(100, 157, 200, 200, 1'b1, 1'b0);
        do_reset();
        p1_attack(ATK_HEAVY);
        check("heavy57_hits", 32'(hits1), 0);
        check("heavy57_hp", 32'(bus.p2_hp), 100);

        // Vertical tolerance boundary
        setup(100, 130, 200, 249, 1'b1, 1'b0);
        do_reset();
        p1_attack(ATK_LIGHT);
        check("dy49_hits", 32'(hits1), 0);
        setup(100, 130, 249, 201, 1'b1, 1'b0);
        do_reset();
        p1_attack(ATK_LIGHT);
        check("dy48_hits", 32'(hits1), 1);

        // Trade: both light, facing each other, same frames
        setup(100, 130, 200, 200, 1'b1, 1'b0);
        do_reset();
        bus.p1_attack_type = ATK_LIGHT;
        bus.p2_attack_type = ATK_LIGHT;
        bus.p1_attack_active = 1'b1;
        bus.p2_attack_active = 1'b1;
        run_frames(0, 10);
        check("trade_pulse", 32'(first_pulse), 32'b11);
        check("trade_frame", 32'(hit_frame), 4);
`ifdef COUNTER_HIT_EN
        check("trade_p1_hp", 32'(bus.p1_hp), 93);
        check("trade_p2_hp", 32'(bus.p2_hp), 93);
`else
        check("trade_p1_hp", 32'(bus.p1_hp), 95);
        check("trade_p2_hp", 32'(bus.p2_hp), 95);
`endif

        // Counter hit: P2 mid-attack (no usable type) when struck by light
        setup(100, 130, 200, 200, 1'b1, 1'b0);
        do_reset();
        bus.p2_attack_active = 1'b1;
        bus.p1_attack_type = ATK_LIGHT;
        bus.p1_attack_active = 1'b1;
        run_frames(0, 10);
        bus.p1_attack_active = 1'b0;
        bus.p2_attack_active = 1'b0;
        idle_ticks(50);
`ifdef COUNTER_HIT_EN
        check("counter_hp", 32'(bus.p2_hp), 93);
        check("counter_stun", 32'(stun2), 40);
`else
        check("counter_hp", 32'(bus.p2_hp), 95);
        check("counter_stun", 32'(stun2), 20);
`endif

        // Drain P2 to 8 hp (6 heavy + 4 light), then a heavy KOs with floor 0
        setup(100, 130, 200, 200, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) p1_attack(ATK_HEAVY);
        for (int i = 0; i < 4; i++) p1_attack(ATK_LIGHT);
        check("pre_ko_hp", 32'(bus.p2_hp), 8);
        check("pre_ko_ko", 32'(bus.ko), 0);
        bus.p1_attack_type = ATK_HEAVY;
        bus.p1_attack_active = 1'b1;
        run_frames(0, 15);
        bus.p1_attack_active = 1'b0;
        check("ko_hp", 32'(bus.p2_hp), 0);
        check("ko_flags", 32'(bus.ko), 32'b10);
        check("ko_stun_on", 32'(bus.p2_hitstun_active), 1);

        // After KO: neither side can land anything; hitstun still drains
        clear_obs();
        bus.p1_attack_type = ATK_LIGHT;
        bus.p2_attack_type = ATK_LIGHT;
        bus.p1_attack_active = 1'b1;
        bus.p2_attack_active = 1'b1;
        run_frames(0, 15);
        bus.p1_attack_active = 1'b0;
        bus.p2_attack_active = 1'b0;
        idle_ticks(30);
        check("post_ko_hits", 32'(hits1 + hits2), 0);
        check("post_ko_p1_hp", 32'(bus.p1_hp), 100);
        check("post_ko_ko", 32'(bus.ko), 32'b10);
        check("post_ko_drain", 32'(bus.p2_hitstun_active), 0);

        do_reset();
        check("ko_rst_hp", 32'(bus.p2_hp), 100);
        check("ko_rst_ko", 32'(bus.ko), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/combat_resolver.md
# combat_resolver

Arbitrates combat between the two `player_core` instances: consumes each player's position, facing and attack outputs, decides hits, and drives each player's `hitstun_active` input. Owns both health counters and the KO flag for the scene/HUD logic. All state advances only on `SCEN` game ticks; outputs are registered.

## Interface
- `POS_WIDTH`, 10: width of x/y positions.
- `HP_WIDTH`, 7: health counter width.
- `HP_MAX`, 100: health at reset.
- `HITSTUN_FRAMES`, 20: ticks of hitstun per hit.
- `REACH_LIGHT`, 40: max |dx| for a type-1 hit.
- `REACH_HEAVY`, 56: max |dx| for a type-2 hit.
- `Y_TOL`, 48: max |dy| for any hit.
- `DMG_LIGHT`, 5 / `DMG_HEAVY`, 12: damage per hit.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `SCEN` in 1: game-tick enable; one-cycle pulse per frame.
- `p1_pos_x`, `p2_pos_x` in POS_WIDTH: player x.
- `p1_pos_y`, `p2_pos_y` in POS_WIDTH: player y.
- `p1_face_right`, `p2_face_right` in 1: facing.
- `p1_attack_active`, `p2_attack_active` in 1: attack in progress.
- `p1_attack_type`, `p2_attack_type` in 2: 1 = light, 2 = heavy, 0/3 = none.
- `p1_attack_frame`, `p2_attack_frame` in 6: frame within attack.
- `p1_hitstun_active`, `p2_hitstun_active` out 1: to each `player_core`.
- `p1_hp`, `p2_hp` out HP_WIDTH: health.
- `hit_pulse` out 2: bit0 = P1 struck P2, bit1 = P2 struck P1; one cycle.
- `ko` out 2: bit0 = P1 down, bit1 = P2 down; sticky.

## Operation
- Reset: hp = HP_MAX both, hitstun counters 0, landed latches 0, `hit_pulse` 0, `ko` 0.
- Hit condition for attacker A on defender D, evaluated only on SCEN cycles:
  - A `attack_active` and type in {1,2};
  - frame in active window: light 4..8, heavy 8..14 inclusive;
  - facing: `face_right` ? D.x >= A.x : D.x <= A.x (dx = 0 hits either way);
  - |A.x − D.x| <= reach(type), |A.y − D.y| <= Y_TOL (unsigned abs diff, POS_WIDTH+1 internal);
  - D hitstun counter == 0; A landed latch clear; `ko` == 0.
- On hit: D hp ← saturating hp − dmg (floor 0); D hitstun ← HITSTUN_FRAMES; A landed latch set; `hit_pulse` bit for A high one cycle.
- Landed latch clears on any SCEN tick where A `attack_active` = 0: one hit per attack max.
- Hitstun counter decrements by 1 per SCEN tick when nonzero; `hitstun_active` = counter != 0.
- Simultaneous hits (trade): both applied same tick, both pulses high.
- KO: set when a player's hp reaches 0; once any `ko` bit set, no further hits; hitstun counters keep draining. Double KO sets both bits.
- Non-SCEN cycles: all state holds; `hit_pulse` 0.

## Timing
- Hit decided on SCEN cycle N; hp, hitstun, `hit_pulse`, `ko` visible cycle N+1.
- `hitstun_active` high for exactly HITSTUN_FRAMES SCEN ticks after the hitting tick.
- Reset mid-hitstun or mid-attack: all state to reset values next edge; reset dominates SCEN.

## Configuration
- `COUNTER_HIT_EN` defined: if D `attack_active` = 1 when struck, damage = dmg + (dmg >> 1) and hitstun = 2·HITSTUN_FRAMES (counter width sized for it).
- Undefined: damage and hitstun independent of defender state.

## Structure
- Package `combat_pkg`: attack type encodings (ATK_NONE, ATK_LIGHT, ATK_HEAVY), active-window bounds, counter widths.
- Sub-module `fighter_damage_track` instantiated once per player: hp register, hitstun counter, landed latch for that player's own attack; top does geometry/hit compare and cross-wiring.

## Test plan
- P1 x=100, P2 x=130, y equal, P1 face_right, light attack frames 0..10 -> exactly one hit at frame 4; P2 hp 100→95; `hit_pulse`=01 one cycle; P2 hitstun 20 ticks.
- Same but P1 face_left -> no hit, hp unchanged.
- Heavy at dx=56 -> hit (hp −12); dx=57 -> no hit; dy=49 -> no hit.
- Both light, dx=30, facing each other, same frames -> trade: both hp 95, `hit_pulse`=11.
- P2 hp 8, heavy hit -> hp 0, `ko`=10, later attacks ignored; reset -> hp 100, `ko`=00.
- `COUNTER_HIT_EN`: P2 attacking when struck by light -> hp −7, hitstun 40 ticks.
